// File: rtl/conv_frame_ctrl.sv
// conv_frame_ctrl: loads the kernel weights into the convolution engine, then feeds one frame of pixels.
// It tags the engine results whose window lies fully inside the frame and emits them with coordinates.
module conv_frame_ctrl #(
  parameter int DIM = 32,
  parameter int K   = 5,
  parameter int WP  = 30,
  parameter int PP  = 8,
  parameter int LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     reuse_w,
  input  logic                     wt_valid,
  output logic                     wt_ready,
  input  logic [WP:0]              wt_data,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  input  logic [PP:0]              pix_data,
  output logic                     eng_wt_we,
  output logic [$clog2(K*K)-1:0]   eng_wt_addr,
  output logic [WP:0]              eng_wt_data,
  output logic                     eng_en,
  output logic [PP:0]              eng_pxl,
  input  logic [PP:0]              eng_out,
  output logic                     out_valid,
  output logic [PP:0]              out_data,
  output logic [$clog2(DIM)-1:0]   out_row,
  output logic [$clog2(DIM)-1:0]   out_col,
  output logic                     busy,
  output logic                     done
);

  localparam int RW = $clog2(DIM);
  localparam int WW = $clog2(K*K);
  localparam int DW = $clog2(LAT+1);

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   widx_q, widx_d;
  logic [RW-1:0]   row_q, row_d, col_q, col_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic            tag_v_q   [LAT];
  logic            tag_v_d   [LAT];
  logic [RW-1:0]   tag_row_q [LAT];
  logic [RW-1:0]   tag_row_d [LAT];
  logic [RW-1:0]   tag_col_q [LAT];
  logic [RW-1:0]   tag_col_d [LAT];
  logic            wt_acc, pix_acc;

  always_comb begin
    state_d   = state_q;
    widx_d    = widx_q;
    row_d     = row_q;
    col_d     = col_q;
    drain_d   = drain_q;
    wt_ready  = 1'b0;
    pix_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = reuse_w ? STREAM : LOAD_W;
      end
      LOAD_W: begin
        wt_ready = 1'b1;
        busy     = 1'b1;
        if (wt_valid) begin
          if (widx_q == WW'(K*K-1)) begin
            widx_d  = '0;
            state_d = STREAM;
          end else begin
            widx_d = widx_q + WW'(1);
          end
        end
      end
      STREAM: begin
        pix_ready = 1'b1;
        busy      = 1'b1;
        if (pix_valid) begin
          if (col_q == RW'(DIM-1)) begin
            col_d = '0;
            if (row_q == RW'(DIM-1)) begin
              row_d   = '0;
              drain_d = '0;
              state_d = DRAIN;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + RW'(1);
          end
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_q == DW'(LAT-1)) begin
          drain_d = '0;
          state_d = DONE;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Engine strobes are gated so they read zero whenever no handshake completes.
  assign wt_acc      = wt_ready & wt_valid;
  assign pix_acc     = pix_ready & pix_valid;
  assign eng_wt_we   = wt_acc;
  assign eng_wt_addr = wt_acc ? widx_q : '0;
  assign eng_wt_data = wt_acc ? wt_data : '0;
  assign eng_en      = pix_acc;
  assign eng_pxl     = pix_acc ? pix_data : '0;

  always_comb begin
    tag_v_d[0]   = pix_acc && (row_q >= RW'(K-1)) && (col_q >= RW'(K-1));
    tag_row_d[0] = row_q - RW'(K-1);
    tag_col_d[0] = col_q - RW'(K-1);
    for (int i = 1; i < LAT; i++) begin
      tag_v_d[i]   = tag_v_q[i-1];
      tag_row_d[i] = tag_row_q[i-1];
      tag_col_d[i] = tag_col_q[i-1];
    end
  end

  assign out_valid = tag_v_q[LAT-1];
  assign out_row   = out_valid ? tag_row_q[LAT-1] : '0;
  assign out_col   = out_valid ? tag_col_q[LAT-1] : '0;
  assign out_data  = out_valid ? eng_out : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      widx_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      drain_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        tag_v_q[i]   <= 1'b0;
        tag_row_q[i] <= '0;
        tag_col_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      row_q   <= row_d;
      col_q   <= col_d;
      drain_q <= drain_d;
      for (int i = 0; i < LAT; i++) begin
        tag_v_q[i]   <= tag_v_d[i];
        tag_row_q[i] <= tag_row_d[i];
        tag_col_q[i] <= tag_col_d[i];
      end
    end
  end

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Self-checking bench for conv_frame_ctrl: a transaction-level model predicts every output each cycle,
// and directed literal checks pin the frame timing and output counts.
module tb_conv_frame_ctrl;

  localparam int DIM = 32;
  localparam int K   = 5;
  localparam int WP  = 30;
  localparam int PP  = 8;
  localparam int LAT = 1;
  localparam int NPIX = DIM*DIM;
  localparam int NW   = K*K;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          reuse_w = 1'b0;
  logic          wt_valid = 1'b0;
  logic          wt_ready;
  logic [WP:0]   wt_data = '0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [PP:0]   pix_data = '0;
  logic          eng_wt_we;
  logic [4:0]    eng_wt_addr;
  logic [WP:0]   eng_wt_data;
  logic          eng_en;
  logic [PP:0]   eng_pxl;
  logic [PP:0]   eng_out = '0;
  logic          out_valid;
  logic [PP:0]   out_data;
  logic [4:0]    out_row;
  logic [4:0]    out_col;
  logic          busy;
  logic          done;

  conv_frame_ctrl #(.DIM(DIM), .K(K), .WP(WP), .PP(PP), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .reuse_w(reuse_w),
    .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_data(wt_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .eng_wt_we(eng_wt_we), .eng_wt_addr(eng_wt_addr), .eng_wt_data(eng_wt_data),
    .eng_en(eng_en), .eng_pxl(eng_pxl), .eng_out(eng_out),
    .out_valid(out_valid), .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in engine: one-cycle latency, result is pixel+1 so the passthrough is visible.
  always @(posedge clk) if (eng_en) eng_out <= eng_pxl + 9'd1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: job phase, accepted counts and a queue of predicted tagged results.
  typedef struct { int due; int row; int col; logic [PP:0] data; } exp_t;
  exp_t exp_q[$];
  int m_ph = 0;
  int m_w = 0;
  int m_n = 0;
  int m_done_at = 0;

  int out_count, first_cyc, first_row, first_col, last_row, last_col, done_cyc, done_count;
  int we_count;
  bit wt_seen;
  logic [WP:0] wmem [NW];

  always @(negedge clk) begin
    logic e_wr, e_pr, e_we, e_en, e_ov, e_busy, e_done;
    logic [31:0] e_addr, e_row, e_col;
    logic [WP:0] e_wd;
    logic [PP:0] e_px, e_od;
    if (!reset) begin
      m_ph = 0; m_w = 0; m_n = 0;
      exp_q.delete();
    end
    e_wr   = (m_ph == 1);
    e_pr   = (m_ph == 2);
    e_we   = e_wr && wt_valid;
    e_addr = e_we ? m_w : 0;
    e_wd   = e_we ? wt_data : '0;
    e_en   = e_pr && pix_valid;
    e_px   = e_en ? pix_data : '0;
    e_busy = (m_ph == 1) || (m_ph == 2) || (m_ph == 3 && cyc < m_done_at);
    e_done = (m_ph == 3) && (cyc == m_done_at);
    e_ov = 1'b0; e_row = 0; e_col = 0; e_od = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e_ov = 1'b1; e_row = exp_q[0].row; e_col = exp_q[0].col; e_od = exp_q[0].data;
      void'(exp_q.pop_front());
    end
    check_output("wt_ready", wt_ready, e_wr);
    check_output("pix_ready", pix_ready, e_pr);
    check_output("eng_wt_we", eng_wt_we, e_we);
    check_output("eng_wt_addr", eng_wt_addr, e_addr);
    check_output("eng_wt_data", eng_wt_data, e_wd);
    check_output("eng_en", eng_en, e_en);
    check_output("eng_pxl", eng_pxl, e_px);
    check_output("out_valid", out_valid, e_ov);
    check_output("out_row", out_row, e_row);
    check_output("out_col", out_col, e_col);
    check_output("out_data", out_data, e_od);
    check_output("busy", busy, e_busy);
    check_output("done", done, e_done);

    // Observed statistics for the directed literal checks.
    if (out_valid) begin
      if (out_count == 0) begin first_cyc = cyc; first_row = out_row; first_col = out_col; end
      last_row = out_row; last_col = out_col;
      out_count++;
    end
    if (done) begin done_cyc = cyc; done_count++; end
    if (wt_ready) wt_seen = 1'b1;
    if (eng_wt_we) begin we_count++; wmem[eng_wt_addr] = eng_wt_data; end

    if (reset) begin
      case (m_ph)
        0: if (start) m_ph = reuse_w ? 2 : 1;
        1: if (e_we) begin
             m_w++;
             if (m_w == NW) begin m_w = 0; m_ph = 2; end
           end
        2: if (e_en) begin
             if (m_n / DIM >= K-1 && m_n % DIM >= K-1)
               exp_q.push_back('{due: cyc + LAT, row: m_n / DIM - (K-1), col: m_n % DIM - (K-1),
                                 data: pix_data + 9'd1});
             m_n++;
             if (m_n == NPIX) begin m_n = 0; m_ph = 3; m_done_at = cyc + LAT + 1; end
           end
        3: if (cyc == m_done_at) m_ph = 0;
        default: m_ph = 0;
      endcase
    end
  end

  int t132, tlast, n_acc;

  task automatic clear_stats();
    out_count = 0; first_cyc = -1; first_row = -1; first_col = -1;
    last_row = -1; last_col = -1; done_cyc = -1; done_count = 0;
    we_count = 0; wt_seen = 1'b0; t132 = -1; tlast = -1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start_job(input logic reuse);
    start = 1'b1; reuse_w = reuse;
    step();
    start = 1'b0; reuse_w = 1'b0;
  endtask

  // mode 0: back-to-back, mode 1: pix_valid toggles every cycle.
  task automatic apply_stimulus(input int mode, input int limit);
    int cycles;
    bit acc;
    n_acc = 0; cycles = 0;
    while (n_acc < limit && cycles < 8000) begin
      pix_valid = (mode == 0) ? 1'b1 : ((cycles % 2) == 0);
      pix_data  = 9'(n_acc);
      @(negedge clk);
      acc = pix_valid && pix_ready;
      if (acc && n_acc == 132) t132 = cyc;
      if (acc && n_acc == NPIX-1) tlast = cyc;
      step();
      if (acc) n_acc++;
      cycles++;
    end
    pix_valid = 1'b0;
    check_output("pixels_accepted", n_acc, limit);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && done_count == 0; i++) step();
    check_output("done_seen", done_count, 1);
  endtask

  task automatic check_frame(input string tag);
    check_output({tag, "_out_count"}, out_count, 784);
    check_output({tag, "_first_lat"}, first_cyc - t132, 1);
    check_output({tag, "_first_row"}, first_row, 0);
    check_output({tag, "_first_col"}, first_col, 0);
    check_output({tag, "_last_row"}, last_row, 27);
    check_output({tag, "_last_col"}, last_col, 27);
    check_output({tag, "_done_lat"}, done_cyc - tlast, 2);
  endtask

  initial begin
    int wi, j;
    bit acc;
    clear_stats();

    $display("[TB] reset with start held high");
    reset = 1'b0; start = 1'b1;
    repeat (5) step();
    reset = 1'b1; start = 1'b0;
    repeat (10) step();
    @(negedge clk);
    check_output("idle_wt_ready", wt_ready, 0);
    check_output("idle_pix_ready", pix_ready, 0);
    step();

    $display("[TB] weight load with stalls, then full frame");
    clear_stats();
    start_job(1'b0);
    wi = 0; j = 0;
    while (wi < NW && j < 200) begin
      wt_valid = ((j % 3) != 2);
      wt_data  = 31'(100 + wi);
      @(negedge clk);
      acc = wt_valid && wt_ready;
      step();
      if (acc) wi++;
      j++;
    end
    wt_valid = 1'b1; wt_data = 31'd125;
    @(negedge clk);
    check_output("w26_wt_ready", wt_ready, 0);
    check_output("w26_pix_ready", pix_ready, 1);
    step();
    wt_valid = 1'b0;
    check_output("we_count", we_count, 25);
    check_output("wmem0", wmem[0], 100);
    check_output("wmem12", wmem[12], 112);
    check_output("wmem24", wmem[24], 124);
    apply_stimulus(0, NPIX);
    wait_done();
    check_frame("frame1");
    repeat (2) step();

    $display("[TB] reuse weights, pix_valid toggling");
    clear_stats();
    start_job(1'b1);
    @(negedge clk);
    check_output("reuse_pix_ready", pix_ready, 1);
    step();
    apply_stimulus(1, NPIX);
    wait_done();
    check_output("reuse_out_count", out_count, 784);
    check_output("reuse_last_row", last_row, 27);
    check_output("reuse_wt_never", wt_seen, 0);
    repeat (2) step();

    $display("[TB] abort after 500 pixels");
    clear_stats();
    start_job(1'b1);
    apply_stimulus(0, 500);
    reset = 1'b0;
    @(negedge clk);
    check_output("abort_out_valid", out_valid, 0);
    check_output("abort_busy", busy, 0);
    step();
    step();
    reset = 1'b1;
    repeat (5) step();
    check_output("abort_no_done", done_count, 0);
    clear_stats();
    start_job(1'b1);
    apply_stimulus(0, NPIX);
    wait_done();
    check_frame("restart");
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_frame_ctrl.md
# conv_frame_ctrl

Sequencer for the 5x5 streaming convolution engine. It loads the K*K kernel weights into the engine over a serial weight stream. It then feeds one DIM x DIM frame of pixels into the engine under valid/ready flow control, with one engine step per accepted pixel. It tags engine outputs whose window lies fully inside the frame and emits them with row/column coordinates, replacing the engine's free-running row/col valid logic.

## Interface
- DIM, 32, image rows/columns
- K, 5, kernel size
- WP, 30, weight MSB index (weights are WP+1 bits signed)
- PP, 8, pixel MSB index (pixels are PP+1 bits signed)
- LAT, 1, engine cycles from an enabled step to the matching result on eng_out (>=1)
- clk  in  1  clock, all state on posedge
- reset  in  1  asynchronous, active-low
- start  in  1  begin a frame job (sampled in IDLE only)
- reuse_w  in  1  sampled with start; 1 = skip weight load
- wt_valid / wt_ready  in / out  1 / 1  weight stream handshake
- wt_data  in  WP+1  weight word, signed, row-major order 00..44
- pix_valid / pix_ready  in / out  1 / 1  pixel stream handshake
- pix_data  in  PP+1  pixel, signed, raster order
- eng_wt_we  out  1  engine weight write strobe
- eng_wt_addr  out  $clog2(K*K)  weight index r*K+c
- eng_wt_data  out  WP+1  weight value
- eng_en  out  1  engine step enable
- eng_pxl  out  PP+1  pixel to engine
- eng_out  in  PP+1  engine result
- out_valid  out  1  result strobe; no backpressure
- out_data  out  PP+1  result (eng_out passthrough)
- out_row, out_col  out  $clog2(DIM) each  output coordinate, 0..DIM-K
- busy  out  1  job in progress
- done  out  1  one-cycle job-complete pulse

## Operation
- States: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE:
  - start=1 and reuse_w=0 -> LOAD_W.
  - start=1 and reuse_w=1 -> STREAM.
  - start in any other state is ignored.
- LOAD_W: wt_ready=1.
  - Each accepted word (wt_valid&wt_ready) drives eng_wt_we=1, eng_wt_addr=widx, eng_wt_data=wt_data combinationally; widx increments.
  - The word accepted at widx=K*K-1 moves the FSM to STREAM and clears widx.
- STREAM: pix_ready=1.
  - eng_en = pix_valid&pix_ready and eng_pxl = pix_data, combinationally. eng_en=0 in every other cycle; the engine holds state.
  - Input counters (r,c) advance on each accepted pixel: c wraps DIM-1->0 and increments r.
  - Each accepted pixel pushes a tag {v = r>=K-1 && c>=K-1, r-(K-1), c-(K-1)} into a LAT-deep tag pipe. The pipe advances every cycle; empty slots have v=0.
  - The pixel accepted at (DIM-1,DIM-1) moves the FSM to DRAIN and clears the counters.
- Output: out_valid = v at the tag-pipe head; out_row/out_col come from the tag, and out_data=eng_out. When v=0, out_valid=0 and out_row/out_col/out_data=0.
- DRAIN: wait LAT cycles (pipe empty) -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- busy=1 in LOAD_W, STREAM and DRAIN; 0 in IDLE and DONE.
- Outputs per frame: (DIM-K+1)^2, which is 784 at the defaults.
- Unsigned counter widths: $clog2(DIM) for r/c, $clog2(K*K) for widx, $clog2(LAT+1) for the drain count.

## Timing
- Reset (async assert): FSM to IDLE; all counters and the tag pipe cleared. Every output reads 0 while reset is low and after release until start.
- Engine weights are not cleared by reset. reuse_w=1 after reset uses stale weights, by design.
- Reset low mid-job aborts immediately. There is no done pulse and no partial out_valid after abort.
- start at cycle t (IDLE) -> wt_ready=1 (or pix_ready=1 if reuse_w=1) at t+1.
- Last weight accepted at t -> pix_ready=1 at t+1.
- Pixel at (r,c) accepted at t -> its tagged result appears with out_valid at t+LAT.
- Last pixel accepted at t -> DRAIN t+1..t+LAT; final out_valid at t+LAT; done at t+LAT+1; IDLE at t+LAT+2.
- The next start is accepted in the IDLE cycle t+LAT+2.
- Handshake stalls (valid low) insert bubbles only and never drop or duplicate data.
- wt_valid outside LOAD_W and pix_valid outside STREAM are ignored (ready=0).

## Test plan
- Reset: hold reset low for 5 cycles with start=1 -> all outputs 0. Release with start=0 -> state IDLE, wt_ready=0, pix_ready=0 indefinitely.
- Weight load: start, reuse_w=0; send words 100..124 with wt_valid low on every third cycle -> 25 eng_wt_we strobes with addr 0..24 matching data 100..124. The 26th offered word sees wt_ready=0 and pix_ready=1.
- Full frame, LAT=1, pixels 0..1023 back-to-back:
  - first out_valid one cycle after pixel 132 is accepted, with out_row=0, out_col=0;
  - exactly 784 out_valid pulses; last at (27,27);
  - done two cycles after pixel 1023 is accepted; busy low with done.
- Backpressure: pix_valid toggling every cycle -> eng_en high only on accepted cycles; still 784 outputs in raster order with correct coordinates; no out_valid for tags with v=0.
- reuse_w=1 start -> wt_ready never asserts; pix_ready=1 the cycle after start; frame completes with 784 outputs.
- Abort: reset asserted after 500 pixels -> outputs 0 in the same cycle, no done pulse. A new start with reuse_w=1 restarts at (0,0), and the first out_valid follows pixel 132 of the new frame.
